// File: rtl/aes_uart_block_tx.sv
// aes_uart_block_tx: serialises one 128-bit block as 16 UART 8N1 bytes, MSB byte first
module aes_uart_block_tx #(
    parameter int CLKS_PER_BIT = 87,
    parameter int STOP_BITS    = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] block_data,
    input  logic         block_valid,
    output logic         block_ready,
    output logic         uart_tx,
    output logic         uart_tx_ready,
    output logic [3:0]   byte_index,
    output logic         frames_sent
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t         state_q, state_d;
    logic [127:0]   blk_q, blk_d;
    logic [7:0]     sh_q, sh_d;
    logic [BW-1:0]  baud_q, baud_d;
    logic [2:0]     bit_q, bit_d;
    logic [3:0]     byte_q, byte_d;
    logic           tx_q, tx_d, fs_q, fs_d, tick;
    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        sh_d    = sh_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        tx_d    = tx_q;
        fs_d    = 1'b0;
        tick    = baud_q == BW'(CLKS_PER_BIT - 1);
        baud_d  = tick ? '0 : baud_q + BW'(1);
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (block_valid) begin
                    state_d = START;
                    blk_d   = {block_data[119:0], 8'h00};
                    sh_d    = block_data[127:120];
                    bit_d   = '0;
                    byte_d  = '0;
                    tx_d    = 1'b0;
                end
            end
            START: if (tick) begin
                state_d = DATA;
                tx_d    = sh_q[0];
            end
            DATA: if (tick) begin
                if (bit_q == 3'd7) begin
                    state_d = STOP;
                    bit_d   = '0;
                    tx_d    = 1'b1;
                end else begin
                    bit_d = bit_q + 3'd1;
                    sh_d  = sh_q >> 1;
                    tx_d  = sh_q[1];
                end
            end
            STOP: if (tick) begin
                // bit counter is reused to count stop bits
                if (bit_q == 3'(STOP_BITS - 1)) begin
                    bit_d = '0;
                    if (byte_q == 4'd15) begin
                        state_d = IDLE;
                        byte_d  = '0;
                        fs_d    = 1'b1;
                    end else begin
                        state_d = START;
                        byte_d  = byte_q + 4'd1;
                        sh_d    = blk_q[127:120];
                        blk_d   = blk_q << 8;
                        tx_d    = 1'b0;
                    end
                end else begin
                    bit_d = bit_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            blk_q   <= '0;
            sh_q    <= '0;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            tx_q    <= 1'b1;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            sh_q    <= sh_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            tx_q    <= tx_d;
            fs_q    <= fs_d;
        end
    end
    assign block_ready   = state_q == IDLE;
    assign uart_tx_ready = state_q == IDLE;
    assign uart_tx       = tx_q;
    assign byte_index    = byte_q;
    assign frames_sent   = fs_q;
endmodule

// File: tb/tb_aes_uart_block_tx.sv
// tb_aes_uart_block_tx: random and directed blocks checked against a per-cycle line model and a bench UART receiver
module tb_aes_uart_block_tx;
    logic         clk = 1'b0, rst = 1'b1, v = 1'b0, use_b = 1'b0;
    logic [127:0] bd = '0;
    logic         va, vb, rdy_a, rdy_b, trdy_a, trdy_b, tx_a, tx_b, fs_a, fs_b;
    logic [3:0]   idx_a, idx_b;
    logic         tx, rdy, fs;
    logic [3:0]   idx;
    int           total = 0, bad = 0;

    always #5 clk = ~clk;
    assign va  = v && !use_b;
    assign vb  = v && use_b;
    assign tx  = use_b ? tx_b : tx_a;
    assign rdy = use_b ? rdy_b : rdy_a;
    assign fs  = use_b ? fs_b : fs_a;
    assign idx = use_b ? idx_b : idx_a;

    aes_uart_block_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut_a (
        .clk(clk), .reset(rst), .block_data(bd), .block_valid(va), .block_ready(rdy_a),
        .uart_tx(tx_a), .uart_tx_ready(trdy_a), .byte_index(idx_a), .frames_sent(fs_a));
    aes_uart_block_tx #(.CLKS_PER_BIT(3), .STOP_BITS(2)) dut_b (
        .clk(clk), .reset(rst), .block_data(bd), .block_valid(vb), .block_ready(rdy_b),
        .uart_tx(tx_b), .uart_tx_ready(trdy_b), .byte_index(idx_b), .frames_sent(fs_b));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Sends one block and checks every cycle from the start bit up to the frames_sent cycle.
    task automatic send(input logic [127:0] data, input int cpb, input int sb, input bit hold,
                        input int poke, input int abort_at, input logic [127:0] nxt);
        int L, D, k, o, ph, e_tx, e_idx, e_fs, e_rdy;
        logic xt;
        logic [7:0] b, rx;
        logic [7:0] q[$];
        L = (9 + sb) * cpb;
        D = 16 * L;
        e_tx = 0; e_idx = 0; e_fs = 0; e_rdy = 0; rx = '0;
        chk("ready_before_accept", rdy, 1);
        bd = data;
        v  = 1'b1;
        @(negedge clk);
        bd = hold ? nxt : ~data;
        v  = hold;
        for (int c = 0; c <= D; c++) begin
            k  = (c < D) ? c / L : 0;
            ph = c % L;
            o  = ph / cpb;
            b  = data[127 - 8 * k -: 8];
            xt = (c == D) ? 1'b1 : (o == 0) ? 1'b0 : (o <= 8) ? b[o - 1] : 1'b1;
            if (tx !== xt) e_tx++;
            if (idx !== 4'(k)) e_idx++;
            if (fs !== (c == D)) e_fs++;
            if (rdy !== (c == D)) e_rdy++;
            if (c < D && o >= 1 && o <= 8 && ph % cpb == cpb / 2) begin
                rx = {tx, rx[7:1]};
                if (o == 8) q.push_back(rx);
            end
            if (c == poke) begin
                v  = 1'b1;
                bd = rnd128();
            end
            if (c == poke + 2 * cpb) v = 1'b0;
            if (c == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                chk("abort_tx", tx, 1);
                chk("abort_ready", rdy, 1);
                chk("abort_idx", idx, 0);
                chk("abort_fs", fs, 0);
                rst = 1'b0;
                return;
            end
            if (c < D) @(negedge clk);
        end
        chk("line_wave_mismatch_cycles", e_tx, 0);
        chk("byte_index_mismatch_cycles", e_idx, 0);
        chk("frames_sent_mismatch_cycles", e_fs, 0);
        chk("ready_mismatch_cycles", e_rdy, 0);
        chk("rx_byte_count", q.size(), 16);
        for (int j = 0; j < 16; j++)
            if (j < q.size()) chk($sformatf("rx_byte%0d", j), q[j], data[127 - 8 * j -: 8]);
    endtask

    initial begin
        logic [127:0] b1, b2;
        // reset held together with valid: nothing may be accepted
        bd = rnd128();
        v  = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_tx", tx_a, 1);
        chk("reset_ready", rdy_a, 1);
        chk("reset_tx_ready", trdy_a, 1);
        chk("reset_idx", idx_a, 0);
        chk("reset_fs", fs_a, 0);
        chk("reset_b_tx", tx_b, 1);
        rst = 1'b0;
        v   = 1'b0;
        @(negedge clk);
        chk("no_accept_after_reset", {rdy_a, tx_a}, 2'b11);
        send(128'h00112233445566778899AABBCCDDEEFF, 4, 1, 0, -1, -1, '0);
        b1 = rnd128();
        b1[127:120] = 8'hA5;
        send(b1, 4, 1, 0, -1, -1, '0);
        send(rnd128(), 4, 1, 0, 3 * 40 + 10, -1, '0);
        b1 = rnd128();
        b2 = rnd128();
        send(b1, 4, 1, 1, -1, -1, b2);
        send(b2, 4, 1, 0, -1, -1, '0);
        send(rnd128(), 4, 1, 0, -1, 7 * 40 + 4 * 3 + 1, '0);
        @(negedge clk);
        send(rnd128(), 4, 1, 0, -1, -1, '0);
        use_b = 1'b1;
        @(negedge clk);
        send(rnd128(), 3, 2, 0, -1, -1, '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
